// File: rtl/cmd_pkg.sv
// Shared constants and state encoding for the ASCII command parser.
package cmd_pkg;

    localparam logic [7:0] CH_RESET = 8'h52;  // "R"
    localparam logic [7:0] CH_SET   = 8'h23;  // "#"
    localparam logic [7:0] CH_QUERY = 8'h3F;  // "?"
    localparam logic [7:0] CH_ACK   = 8'h2A;  // "*"
    localparam logic [7:0] CH_ERR   = 8'h21;  // "!"
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CH,
        ST_GET_DIGITS,
        ST_COMMIT,
        ST_STAT_CH,
        ST_STAT_SEND,
        ST_SEND_ACK,
        ST_SEND_ERR
    } state_t;

endpackage

// File: rtl/hex_ascii.sv
// Combinational hex nibble <-> ASCII converter; encode emits uppercase,
// decode accepts 0-9, A-F and a-f.
module hex_ascii (
    input  logic [3:0] nib,
    output logic [7:0] enc,
    input  logic [7:0] chr,
    output logic [3:0] dec,
    output logic       dec_ok
);

    always_comb begin
        if (nib < 4'd10) enc = 8'h30 + {4'h0, nib};
        else             enc = 8'h37 + {4'h0, nib};
    end

    always_comb begin
        dec    = 4'h0;
        dec_ok = 1'b0;
        if (chr >= 8'h30 && chr <= 8'h39) begin
            dec    = chr[3:0];
            dec_ok = 1'b1;
        end else if ((chr >= 8'h41 && chr <= 8'h46) || (chr >= 8'h61 && chr <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10
            dec    = chr[3:0] + 4'd9;
            dec_ok = 1'b1;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// UART command parser: plain command codes, "#<ch><hex>" argument writes
// and "?<ch>" status reads answered in uppercase hex.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int ARG_WIDTH      = 16,
    parameter int NUM_ARGS       = 4,
    parameter int STATUS_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       rxData,
    input  logic                             rxValid,
    input  logic [NUM_ARGS*STATUS_WIDTH-1:0] statusIn,
    input  logic                             txReady,
    output logic [7:0]                       txData,
    output logic                             txDataWr,
    output logic [7:0]                       cmdCode,
    output logic                             cmdStrobe,
    output logic [NUM_ARGS*ARG_WIDTH-1:0]    argValue,
    output logic [NUM_ARGS-1:0]              argUpdate
);

    localparam int NDIG  = ARG_WIDTH / 4;
    localparam int DW    = $clog2(NDIG + 1);
    localparam int NSTAT = STATUS_WIDTH / 4;
    localparam int SCW   = $clog2(NSTAT + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_nxt;
    logic [3:0]              ch;
    logic [DW-1:0]           dig_cnt;
    logic [ARG_WIDTH-1:0]    shadow;
    logic [ARG_WIDTH-1:0]    arg_q [NUM_ARGS];
    logic [STATUS_WIDTH-1:0] snap;
    logic [SCW-1:0]          stat_cnt;
    logic [TW-1:0]           to_cnt;

    logic       is_r, ch_ok, wait_st, to_hit;
    logic       cmd_ld, ch_ld, dig_ld, commit, snap_ld, tx_wr;
    logic [7:0] tx_byte;
    logic [3:0] rx_nib;
    logic       rx_hex;
    logic [7:0] stat_chr;
    logic [7:0] unused_enc;
    logic [3:0] unused_dec;
    logic       unused_ok;

    hex_ascii u_dec (
        .nib    (4'h0),
        .enc    (unused_enc),
        .chr    (rxData),
        .dec    (rx_nib),
        .dec_ok (rx_hex)
    );

    hex_ascii u_enc (
        .nib    (snap[STATUS_WIDTH-1 -: 4]),
        .enc    (stat_chr),
        .chr    (8'h00),
        .dec    (unused_dec),
        .dec_ok (unused_ok)
    );

    assign is_r    = rxValid && (rxData == CH_RESET);
    assign ch_ok   = (rxData >= CH_ZERO) && (rxData <= CH_NINE) &&
                     ({28'd0, rxData[3:0]} < 32'(NUM_ARGS));
    assign wait_st = (state == ST_GET_CH) || (state == ST_GET_DIGITS) || (state == ST_STAT_CH);
    assign to_hit  = wait_st && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ld    = 1'b0;
        ch_ld     = 1'b0;
        dig_ld    = 1'b0;
        commit    = 1'b0;
        snap_ld   = 1'b0;
        tx_wr     = 1'b0;
        tx_byte   = 8'h00;
        // "R" wins over everything, including a pending transmit write
        if (is_r) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rxValid) begin
                        if (rxData == CH_SET)        state_nxt = ST_GET_CH;
                        else if (rxData == CH_QUERY) state_nxt = ST_STAT_CH;
                        else                         cmd_ld    = 1'b1;
                    end
                end
                ST_GET_CH: begin
                    if (rxValid) begin
                        if (ch_ok) begin
                            ch_ld     = 1'b1;
                            state_nxt = ST_GET_DIGITS;
                        end else begin
                            state_nxt = ST_SEND_ERR;
                        end
                    end else if (to_hit) begin
                        state_nxt = ST_SEND_ERR;
                    end
                end
                ST_GET_DIGITS: begin
                    if (rxValid) begin
                        if (rx_hex) begin
                            dig_ld = 1'b1;
                            if (dig_cnt == DW'(NDIG - 1)) state_nxt = ST_COMMIT;
                        end else begin
                            state_nxt = ST_SEND_ERR;
                        end
                    end else if (to_hit) begin
                        state_nxt = ST_SEND_ERR;
                    end
                end
                ST_COMMIT: begin
                    commit    = 1'b1;
                    state_nxt = ST_SEND_ACK;
                end
                ST_STAT_CH: begin
                    if (rxValid) begin
                        if (ch_ok) begin
                            ch_ld     = 1'b1;
                            snap_ld   = 1'b1;
                            state_nxt = ST_STAT_SEND;
                        end else begin
                            state_nxt = ST_SEND_ERR;
                        end
                    end else if (to_hit) begin
                        state_nxt = ST_SEND_ERR;
                    end
                end
                ST_STAT_SEND: begin
                    tx_byte = stat_chr;
                    if (txReady) begin
                        tx_wr = 1'b1;
                        if (stat_cnt == SCW'(NSTAT - 1)) state_nxt = ST_IDLE;
                    end
                end
                ST_SEND_ACK: begin
                    tx_byte = CH_ACK;
                    if (txReady) begin
                        tx_wr     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_SEND_ERR: begin
                    tx_byte = CH_ERR;
                    if (txReady) begin
                        tx_wr     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Transmit outputs are decoded from state so an async reset kills them at once
    assign txData   = tx_byte;
    assign txDataWr = tx_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdCode   <= 8'h00;
            cmdStrobe <= 1'b0;
            argUpdate <= '0;
            ch        <= 4'h0;
            dig_cnt   <= '0;
            shadow    <= '0;
            snap      <= '0;
            stat_cnt  <= '0;
            to_cnt    <= '0;
            for (int k = 0; k < NUM_ARGS; k++) arg_q[k] <= '0;
        end else begin
            cmdStrobe <= cmd_ld;
            argUpdate <= '0;
            if (cmd_ld) cmdCode <= rxData;

            if (ch_ld) begin
                ch      <= rxData[3:0];
                dig_cnt <= '0;
                shadow  <= '0;
            end else if (dig_ld) begin
                shadow  <= (shadow << 4) | ARG_WIDTH'(rx_nib);
                dig_cnt <= dig_cnt + DW'(1);
            end

            if (commit) begin
                for (int k = 0; k < NUM_ARGS; k++) begin
                    if (ch == 4'(k)) begin
                        arg_q[k]     <= shadow;
                        argUpdate[k] <= 1'b1;
                    end
                end
            end

            if (snap_ld) begin
                stat_cnt <= '0;
                for (int k = 0; k < NUM_ARGS; k++)
                    if (rxData[3:0] == 4'(k)) snap <= statusIn[k*STATUS_WIDTH +: STATUS_WIDTH];
            end else if (tx_wr && state == ST_STAT_SEND) begin
                snap     <= snap << 4;
                stat_cnt <= stat_cnt + SCW'(1);
            end

            if (rxValid || !wait_st) to_cnt <= '0;
            else if (!to_hit)        to_cnt <= to_cnt + TW'(1);
        end
    end

    for (genvar k = 0; k < NUM_ARGS; k++) begin : g_pack
        assign argValue[k*ARG_WIDTH +: ARG_WIDTH] = arg_q[k];
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: stimulus pushes expected tx bytes,
// argument updates and command strobes; a negedge monitor pops and compares.
module tb_cmd_parser;

    localparam int AW = 16;
    localparam int NA = 4;
    localparam int SW = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         rxData;
    logic               rxValid;
    logic [NA*SW-1:0]   statusIn;
    logic               txReady;
    logic [7:0]         txData;
    logic               txDataWr;
    logic [7:0]         cmdCode;
    logic               cmdStrobe;
    logic [NA*AW-1:0]   argValue;
    logic [NA-1:0]      argUpdate;

    cmd_parser #(
        .ARG_WIDTH(AW), .NUM_ARGS(NA), .STATUS_WIDTH(SW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxValid(rxValid),
        .statusIn(statusIn), .txReady(txReady), .txData(txData), .txDataWr(txDataWr),
        .cmdCode(cmdCode), .cmdStrobe(cmdStrobe), .argValue(argValue), .argUpdate(argUpdate)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] mask; int ch; logic [15:0] val; int cyc; } upd_t;
    typedef struct { logic [7:0] code; int cyc; } cmd_t;

    logic [7:0] exp_tx[$];
    upd_t       exp_upd[$];
    cmd_t       exp_cmd[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] arg_model [NA];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the head of its queue
    always @(negedge clk) begin
        logic [7:0] et;
        upd_t eu;
        cmd_t ec;
        if (rst_n) begin
            if (txDataWr) begin
                check("tx_ready_gate", {31'd0, txReady}, 32'd1);
                if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, txData}, 32'hFFFF_FFFF);
                else begin
                    et = exp_tx.pop_front();
                    check("tx_byte", {24'd0, txData}, {24'd0, et});
                end
            end
            if (cmdStrobe) begin
                if (exp_cmd.size() == 0) check("cmd_unexpected", {24'd0, cmdCode}, 32'hFFFF_FFFF);
                else begin
                    ec = exp_cmd.pop_front();
                    check("cmd_code", {24'd0, cmdCode}, {24'd0, ec.code});
                    check("cmd_latency", cyc, ec.cyc);
                end
            end
            if (argUpdate != '0) begin
                if (exp_upd.size() == 0) check("upd_unexpected", {28'd0, argUpdate}, 32'hFFFF_FFFF);
                else begin
                    eu = exp_upd.pop_front();
                    check("upd_mask", {28'd0, argUpdate}, {28'd0, eu.mask});
                    check("upd_value", {16'd0, argValue[eu.ch*AW +: AW]}, {16'd0, eu.val});
                    check("upd_latency", cyc, eu.cyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] c);
        rxData  = c;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Write command: last digit is driven at the current cycle, update lands 2 later
    task automatic write_arg(input int ch, input string digits, input logic [15:0] val);
        logic [7:0] chc;
        chc = 8'h30 + 8'(ch);
        send(8'h23);
        send(chc);
        for (int i = 0; i < digits.len(); i++) begin
            if (i == digits.len() - 1) begin
                exp_upd.push_back('{mask: 4'(1 << ch), ch: ch, val: val, cyc: cyc + 2});
                arg_model[ch] = val;
            end
            send(digits[i]);
        end
    endtask

    task automatic drain(input int max, input bit toggle);
        int n;
        n = 0;
        while ((exp_tx.size() + exp_upd.size() + exp_cmd.size()) != 0 && n < max) begin
            @(posedge clk); #1;
            if (toggle) txReady = ~txReady;
            n++;
        end
        if (n >= max) check("drain_timeout", n, 32'(max - 1));
        txReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_args(input string name);
        for (int k = 0; k < NA; k++) check(name, {16'd0, argValue[k*AW +: AW]}, {16'd0, arg_model[k]});
    endtask

    initial begin
        rst_n    = 1'b0;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        txReady  = 1'b1;
        statusIn = {16'hBEEF, 16'h0000, 16'h0000, 16'h0123};
        for (int k = 0; k < NA; k++) arg_model[k] = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_txwr", {31'd0, txDataWr}, 32'd0);
        check("rst_txdata", {24'd0, txData}, 32'd0);
        check("rst_cmdcode", {24'd0, cmdCode}, 32'd0);
        check("rst_cmdstrobe", {31'd0, cmdStrobe}, 32'd0);
        check("rst_argupdate", {28'd0, argUpdate}, 32'd0);
        check_args("rst_argvalue");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // plain command
        exp_cmd.push_back('{code: 8'h41, cyc: cyc + 1});
        send(8'h41);
        drain(20, 1'b0);

        // "#2" "1A3f"
        write_arg(2, "1A3f", 16'h1A3F);
        exp_tx.push_back(8'h2A);
        drain(20, 1'b0);
        check_args("after_write2");

        // channel out of range
        exp_tx.push_back(8'h21);
        send_str("#5");
        drain(20, 1'b0);

        // bad hex digit
        exp_tx.push_back(8'h21);
        send_str("#112G");
        drain(20, 1'b0);
        check_args("after_bad_hex");

        // timeout inside a sequence
        exp_tx.push_back(8'h21);
        send_str("#012");
        drain(200, 1'b0);
        check_args("after_timeout");

        // status read with txReady toggling
        exp_tx.push_back("B"); exp_tx.push_back("E");
        exp_tx.push_back("E"); exp_tx.push_back("F");
        send_str("?3");
        drain(40, 1'b1);

        exp_tx.push_back("0"); exp_tx.push_back("1");
        exp_tx.push_back("2"); exp_tx.push_back("3");
        send_str("?0");
        drain(20, 1'b0);

        // "R" aborts, following "X" is a plain command
        send_str("#11");
        send(8'h52);
        exp_cmd.push_back('{code: 8'h58, cyc: cyc + 1});
        send(8'h58);
        drain(20, 1'b0);
        check_args("after_abort");

        // lowercase digits into channel 0
        write_arg(0, "abcd", 16'hABCD);
        exp_tx.push_back(8'h2A);
        drain(20, 1'b0);

        // all-ones into top channel; a character sent during ACK wait is ignored
        txReady = 1'b0;
        write_arg(3, "FFFF", 16'hFFFF);
        exp_tx.push_back(8'h2A);
        repeat (3) @(posedge clk);
        #1;
        send(8'h51);
        repeat (2) @(posedge clk);
        #1;
        txReady = 1'b1;
        drain(20, 1'b0);
        check_args("after_write3");

        // reset while a status byte is being offered
        txReady = 1'b0;
        send_str("?3");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        txReady = 1'b1;
        #1;
        check("tx_before_rst", {31'd0, txDataWr}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("tx_drop_on_rst", {31'd0, txDataWr}, 32'd0);
        for (int k = 0; k < NA; k++) arg_model[k] = 16'h0000;
        check_args("rst_clears_args");
        check("rst_cmdcode2", {24'd0, cmdCode}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        check("left_tx", exp_tx.size(), 32'd0);
        check("left_upd", exp_upd.size(), 32'd0);
        check("left_cmd", exp_cmd.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter ARG_WIDTH, default 16: bits per argument register; SHALL be a multiple of 4.
REQ-002 Parameter NUM_ARGS, default 4: argument channels, 1..10, addressed by ASCII digit '0'..'9'.
REQ-003 Parameter STATUS_WIDTH, default 16: bits per status channel; SHALL be a multiple of 4.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle gap between characters inside a sequence.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rxData  in  8  received UART character.
REQ-008 rxValid  in  1  one-cycle strobe qualifying rxData.
REQ-009 statusIn  in  NUM_ARGS*STATUS_WIDTH  per-channel status words; channel k occupies bits [k*STATUS_WIDTH +: STATUS_WIDTH].
REQ-010 txReady  in  1  UART transmitter can accept a byte this cycle.
REQ-011 txData  out  8  byte to transmit.
REQ-012 txDataWr  out  1  one-cycle write strobe, asserted only while txReady is high.
REQ-013 cmdCode  out  8  last plain command character.
REQ-014 cmdStrobe  out  1  one-cycle pulse when cmdCode is updated.
REQ-015 argValue  out  NUM_ARGS*ARG_WIDTH  argument registers, same packing as statusIn.
REQ-016 argUpdate  out  NUM_ARGS  one-cycle pulse on the channel whose argValue just changed.

Function
REQ-017 States: IDLE, GET_CH, GET_DIGITS, COMMIT, STAT_CH, STAT_SEND, SEND_ACK, SEND_ERR.
REQ-018 In any state, rxValid with rxData=="R" SHALL force IDLE next cycle, discard the partial sequence, and produce no tx, update, or strobe.
REQ-019 IDLE: "#" -> GET_CH; "?" -> STAT_CH; any other character -> cmdCode<=rxData and cmdStrobe high for one cycle; the state stays IDLE.
REQ-020 GET_CH: digit d < NUM_ARGS -> latch channel and go to GET_DIGITS with the digit counter cleared; any other character -> SEND_ERR.
REQ-021 GET_DIGITS: accept ARG_WIDTH/4 hex digits (0-9, A-F, a-f), MSB first, shifted into a shadow register; an invalid character -> SEND_ERR.
REQ-022 After the last digit, go to COMMIT; COMMIT copies the shadow into the channel's argValue, pulses argUpdate for one cycle, then goes to SEND_ACK.
REQ-023 argValue of a channel SHALL change only in COMMIT; errors, timeouts and "R" leave it unchanged.
REQ-024 STAT_CH: a valid digit latches the channel and snapshots its statusIn word on the same cycle, then goes to STAT_SEND; an invalid digit -> SEND_ERR.
REQ-025 STAT_SEND: transmit STATUS_WIDTH/4 uppercase hex characters of the snapshot, MSB first, one per txReady cycle, then go to IDLE with no ACK.
REQ-026 SEND_ACK transmits "*"; SEND_ERR transmits "!"; each waits for txReady, writes once, then goes to IDLE.
REQ-027 Characters arriving while in a transmit state are ignored, except "R".
REQ-028 Timeout: in GET_CH, GET_DIGITS or STAT_CH, a counter is cleared on every rxValid; reaching TIMEOUT_CYCLES -> SEND_ERR.
REQ-029 Latency: argUpdate is asserted 2 cycles after the rxValid of the final digit; cmdStrobe is asserted 1 cycle after rxValid.
REQ-030 The hex digit counter SHALL be $clog2(ARG_WIDTH/4+1) bits wide; the timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide.

Reset
REQ-031 rst_n low: state IDLE; txData, txDataWr, cmdCode, cmdStrobe, argUpdate, counters and shadow all zero.
REQ-032 rst_n low: argValue zero for all channels.
REQ-033 Reset asserted mid-transmit SHALL drop txDataWr immediately.

Structure
REQ-034 ASCII constants ("R", "#", "?", "*", "!") and the state encoding SHALL live in the shared package cmd_pkg.
REQ-035 Hex encode and decode SHALL be one combinational sub-module, hex_ascii, instantiated twice.

Verification (ARG_WIDTH=16, NUM_ARGS=4, STATUS_WIDTH=16, TIMEOUT_CYCLES=100, txReady high)
REQ-036 "#2" then "1A3f" -> channel 2 argValue = 0x1A3F, argUpdate = 4'b0100 for 1 cycle, tx "*".
REQ-037 "#5" -> tx "!"; no argUpdate.
REQ-038 "#1" then "12G" -> tx "!"; channel 1 unchanged.
REQ-039 "#0" then "12", followed by 100 idle cycles -> tx "!"; channel 0 unchanged.
REQ-040 statusIn channel 3 = 0xBEEF, "?3" -> tx "B","E","E","F" in order; with txReady toggled, each byte is written only while txReady is high.
REQ-041 "#1","1","R","X" -> no tx, no argUpdate; cmdStrobe with cmdCode = 0x58.
